// File: rtl/lab2_proc_imul_arbiter_if.sv
// Handshake bundle between requesters, the arbiter and the shared multiplier.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface lab2_proc_imul_arbiter_if #(
    parameter int p_num_reqs   = 4,
    parameter int p_req_nbits  = 64,
    parameter int p_resp_nbits = 32
);
    logic [p_num_reqs-1:0]             req_val;
    logic [p_num_reqs-1:0]             req_rdy;
    logic [p_num_reqs*p_req_nbits-1:0] req_msg;
    logic [p_num_reqs-1:0]             resp_val;
    logic [p_num_reqs-1:0]             resp_rdy;
    logic [p_resp_nbits-1:0]           resp_msg;
    logic                              mul_req_val;
    logic                              mul_req_rdy;
    logic [p_req_nbits-1:0]            mul_req_msg;
    logic                              mul_resp_val;
    logic                              mul_resp_rdy;
    logic [p_resp_nbits-1:0]           mul_resp_msg;

    modport slave (
        input  req_val, req_msg, resp_rdy,
        input  mul_req_rdy, mul_resp_val, mul_resp_msg,
        output req_rdy, resp_val, resp_msg,
        output mul_req_val, mul_req_msg, mul_resp_rdy
    );

    modport master (
        output req_val, req_msg, resp_rdy,
        output mul_req_rdy, mul_resp_val, mul_resp_msg,
        input  req_rdy, resp_val, resp_msg,
        input  mul_req_val, mul_req_msg, mul_resp_rdy
    );
endinterface

// File: rtl/lab2_proc_imul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among several requesters.
// One multiply in flight at a time; the response is steered back to its issuer.
module lab2_proc_imul_arbiter #(
    parameter int p_num_reqs   = 4,
    parameter int p_req_nbits  = 64,
    parameter int p_resp_nbits = 32,
    localparam int c_ow = $clog2(p_num_reqs)
) (
    input  logic                   clk,
    input  logic                   reset,
    lab2_proc_imul_arbiter_if.slave bus,
    output logic [c_ow-1:0]        owner,
    output logic                   busy,
    output logic [31:0]            num_issued
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [c_ow-1:0] ptr;
    logic [c_ow-1:0] gnt;
    logic [c_ow-1:0] gnt_nxt;
    logic            gnt_any;
    logic            idle;
    logic            issue;
    logic            done;

    assign idle = (state == IDLE);
    assign busy = (state == BUSY);

    // Scan from ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        int              j;
        logic [c_ow-1:0] idx;
        gnt_any = 1'b0;
        gnt     = '0;
        j       = 0;
        idx     = '0;
        for (int k = 0; k < p_num_reqs; k++) begin
            j = int'(ptr) + k;
            if (j >= p_num_reqs) j = j - p_num_reqs;
            idx = c_ow'(j);
            if (!gnt_any && bus.req_val[idx]) begin
                gnt_any = 1'b1;
                gnt     = idx;
            end
        end
    end

    assign gnt_nxt = (gnt == c_ow'(p_num_reqs - 1)) ? '0 : gnt + 1'b1;

    assign issue = reset & idle & gnt_any & bus.mul_req_rdy;
    assign done  = reset & busy & bus.mul_resp_val & bus.resp_rdy[owner];

    always_comb begin
        bus.req_rdy      = '0;
        bus.resp_val     = '0;
        bus.mul_req_val  = 1'b0;
        bus.mul_req_msg  = '0;
        bus.mul_resp_rdy = 1'b0;
        bus.resp_msg     = bus.mul_resp_msg;
        if (reset) begin
            if (idle) begin
                bus.mul_req_val = |bus.req_val;
                for (int i = 0; i < p_num_reqs; i++) begin
                    if (gnt_any && gnt == c_ow'(i)) begin
                        bus.mul_req_msg = bus.req_msg[i*p_req_nbits +: p_req_nbits];
                    end
                end
                if (gnt_any) bus.req_rdy[gnt] = bus.mul_req_rdy;
            end else begin
                bus.resp_val[owner] = bus.mul_resp_val;
                bus.mul_resp_rdy    = bus.resp_rdy[owner];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            num_issued <= '0;
        end else begin
            unique case (1'b1)
                issue: begin
                    owner      <= gnt;
                    ptr        <= gnt_nxt;
                    num_issued <= num_issued + 32'd1;
                    state      <= BUSY;
                end
                done: begin
                    state <= IDLE;
                end
                default: ;
            endcase
        end
    end

    a_req_rdy_onehot0: assert property (
        @(posedge clk) disable iff (!reset) $onehot0(bus.req_rdy));

    a_resp_val_onehot0: assert property (
        @(posedge clk) disable iff (!reset) $onehot0(bus.resp_val));

endmodule
